color_receiver: RTL and testbench

//  UART 8N1 receiver: the inbound counterpart of color_transmitter on the Basys 3 USB-UART link.

---
 rtl/color_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/color_receiver.sv | 114 +++++++++++
 tb/tb_color_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// color_pkg
//   Definitions shared by color_receiver and color_transmitter, so that both
//   ends of the USB-UART link agree on baud derivation, byte order and the
//   byte-level state encoding.
//   Contents:
//     clks_per_bit()   - clock cycles per UART bit for a clock/baud pair
//     BYTES_PER_PIXEL  - bytes in one RGB pixel (R first, then G, then B)
//     ST_*             - byte FSM state encoding
//     rgb_t            - 24-bit pixel type
package color_pkg;

  localparam int BYTES_PER_PIXEL = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [23:0] rgb_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 byte deserialiser: 2-flop synchroniser on the serial input followed
//   by an IDLE/START/DATA/STOP state machine that samples each bit at its
//   centre.
//   Ports:
//     clk       in   system clock
//     reset_n   in   asynchronous active-low reset
//     rxd       in   serial input, idle high, asynchronous to clk
//     rx_byte   out  last byte shifted in (meaningful while byte_stb = 1)
//     byte_stb  out  one-cycle pulse: byte received with a good stop bit
//     stop_err  out  one-cycle pulse: stop bit sampled low, byte dropped
//     active    out  FSM is not IDLE
module uart_rx_byte
  import color_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       stop_err,
  output logic       active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_s1;
  logic          rx_s2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Synchroniser stage; preset high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  // Byte FSM stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_stb <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      stop_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s2) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line back high at mid-start was a glitch: drop it silently.
            state   <= rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= ST_STOP;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // Leave from mid-stop so a back-to-back start edge is not missed.
          if (cnt == FULL_LAST) begin
            cnt      <= '0;
            byte_stb <= rx_s2;
            stop_err <= ~rx_s2;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Data shift register, LSB first; qualified by byte_stb so needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && cnt == FULL_LAST) shift <= {rx_s2, shift[7:1]};
  end

  assign rx_byte = shift;
  assign active  = (state != ST_IDLE);

endmodule

// File: rtl/color_receiver.sv
// color_receiver
//   UART 8N1 receiver that assembles every three bytes (R, G, B) into one
//   24-bit pixel and presents it through a one-entry valid/ready register.
//   A partial pixel is abandoned after TIMEOUT_BITS idle bit-times or on a
//   framing error.
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     RxD        in   serial input, idle high
//     rgb        out  pixel {R, G, B}
//     valid      out  rgb holds an unconsumed pixel
//     ready      in   consumer accepts on valid & ready
//     busy       out  inside a byte or holding a partial pixel
//     frame_err  out  sticky: a stop bit was sampled low
//     overrun    out  sticky: a pixel arrived while the register was full
module color_receiver
  import color_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RxD,
  output logic [23:0] rgb,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TLIM         = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TLIM + 1);
  localparam logic [TW-1:0] TLIM_W   = TW'(TLIM);
  localparam logic [1:0]    LAST_IDX = 2'(BYTES_PER_PIXEL - 1);

  logic [7:0]    rx_byte;
  logic          byte_stb;
  logic          stop_err;
  logic          rx_active;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    slot_r;
  logic [7:0]    slot_g;
  logic          pixel_done;
  rgb_t          pixel;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (RxD),
    .rx_byte  (rx_byte),
    .byte_stb (byte_stb),
    .stop_err (stop_err),
    .active   (rx_active)
  );

  assign pixel_done = byte_stb && (idx == LAST_IDX);
  assign pixel      = {slot_r, slot_g, rx_byte};
  assign busy       = rx_active || (idx != 2'd0);

  // Byte slots: only read once all three bytes have arrived, so no reset.
  always_ff @(posedge clk) begin
    if (byte_stb) begin
      case (idx)
        2'd0:    slot_r <= rx_byte;
        2'd1:    slot_g <= rx_byte;
        default: ;
      endcase
    end
  end

  // Assembly, timeout and holding register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      tcnt      <= '0;
      rgb       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Gap counter only runs between bytes of a started pixel.
      if (rx_active || idx == 2'd0) tcnt <= '0;
      else if (tcnt != TLIM_W)      tcnt <= tcnt + 1'b1;

      if (stop_err) begin
        frame_err <= 1'b1;
        idx       <= '0;
      end else if (byte_stb) begin
        idx <= pixel_done ? 2'd0 : idx + 2'd1;
      end else if (tcnt == TLIM_W) begin
        idx <= '0;
      end

      if (pixel_done) begin
        if (!valid || ready) begin
          rgb   <= pixel;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_color_receiver.sv
// tb_color_receiver
//   Directed and randomized serial stimulus for color_receiver at 16 clocks
//   per bit, checked against a byte/pixel-level reference model.
module tb_color_receiver;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RxD;
  logic        ready;
  logic [23:0] rgb;
  logic        valid;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  always #5 clk = ~clk;

  color_receiver #(
    .CLK_FREQ     (1_600_000),
    .BAUD         (100_000),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .RxD       (RxD),
    .rgb       (rgb),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];

  // Reference model state
  int          m_idx;
  logic [7:0]  m_slot[3];
  logic        m_valid;
  logic [23:0] m_rgb;
  logic        m_ovr;
  logic        m_ferr;

  always @(posedge clk) begin
    if (reset_n && valid && ready) got_q.push_back(rgb);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_idx   = 0;
    m_valid = 1'b0;
    m_rgb   = '0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop);
    logic [23:0] pix;
    if (!stop) begin
      m_ferr = 1'b1;
      m_idx  = 0;
    end else begin
      m_slot[m_idx] = b;
      m_idx++;
      if (m_idx == 3) begin
        m_idx = 0;
        pix = {m_slot[0], m_slot[1], m_slot[2]};
        if (ready)         exp_q.push_back(pix);
        else if (!m_valid) begin m_valid = 1'b1; m_rgb = pix; end
        else               m_ovr = 1'b1;
      end
    end
  endtask

  task automatic bit_time(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    RxD = 1'b1;
    model_byte(b, stop);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    send_byte(p[23:16], 1'b1);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * CPB) @(negedge clk);
    if (n >= TOB + 2) m_idx = 0;
  endtask

  task automatic glitch(input int n);
    RxD = 1'b0;
    repeat (n) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({tag, "_rgb"}, {8'h0, got_q[i]}, {8'h0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, frame_err, m_ferr);
    chk({tag, "_overrun"}, overrun, m_ovr);
    chk({tag, "_valid"}, valid, m_valid);
    chk({tag, "_busy"}, busy, (m_idx != 0));
  endtask

  initial begin
    reset_n = 1'b0;
    RxD     = 1'b1;
    ready   = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rgb", rgb, 24'h0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    idle_bits(2);

    // Back-to-back pixel
    send_pixel(24'hA53C7E);
    idle_bits(2);
    check_stream("b2b");
    check_flags("b2b");

    // Short low glitch is rejected
    glitch(4);
    idle_bits(2);
    check_flags("glitch");
    check_stream("glitch");
    send_pixel(24'h112233);
    idle_bits(2);
    check_stream("after_glitch");

    // Framing error drops the byte and any partial pixel
    send_byte(8'h55, 1'b0);
    idle_bits(2);
    send_byte(8'h01, 1'b1);
    idle_bits(1);
    check_flags("partial");
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle_bits(2);
    check_stream("frame_err");
    check_flags("frame_err");

    // Holding register full -> overrun, first pixel kept
    ready = 1'b0;
    send_pixel(24'h010203);
    chk("hold_valid_latency", valid, m_valid);
    send_pixel(24'h040506);
    idle_bits(2);
    chk("hold_rgb", rgb, m_rgb);
    check_flags("overrun");
    ready = 1'b1;
    exp_q.push_back(m_rgb);
    m_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_stream("drain");
    chk("drain_valid", valid, m_valid);

    // Inter-byte timeout discards the partial pixel silently
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle_bits(25);
    check_flags("timeout");
    send_pixel(24'h102030);
    idle_bits(2);
    check_stream("timeout");

    // Reset in the middle of byte 1
    send_byte(8'h12, 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    reset_n = 1'b0;
    #1;
    chk("midreset_rgb", rgb, 24'h0);
    chk("midreset_valid", valid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_frame_err", frame_err, 1'b0);
    chk("midreset_overrun", overrun, 1'b0);
    RxD = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(2);
    send_pixel(24'hC0FFEE);
    idle_bits(2);
    check_stream("post_reset");
    check_flags("post_reset");

    // Randomized pixels, gaps, glitches and an occasional bad stop bit
    for (int p = 0; p < 10; p++) begin
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 5));
      for (int k = 0; k < 3; k++) begin
        if (p == 4 && k == 1) begin
          send_byte(8'($urandom), 1'b0);
          idle_bits(2);
        end
        send_byte(8'($urandom), 1'b1);
        idle_bits($urandom_range(0, 4));
      end
    end
    idle_bits(2);
    check_stream("random");
    check_flags("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
